// File: rtl/csr_trap_ctrl.sv
// Trap/return sequencer in front of the CSR register file: passes execute-stage CSR
// accesses through when idle and runs the mepc/mcause/mstatus/mtvec sequences for traps and mret.
module csr_trap_ctrl #(
  parameter logic [31:0] IRQ_CAUSE    = 32'h8000_000B,
  parameter logic [31:0] ECALL_CAUSE  = 32'd11,
  parameter logic [31:0] EBREAK_CAUSE = 32'd3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        mret_i,
  input  logic        irq_i,
  input  logic [31:0] inst_addr_i,
  input  logic [11:0] ex_csr_raddr_i,
  input  logic        ex_csr_re_i,
  input  logic [11:0] ex_csr_waddr_i,
  input  logic        ex_csr_we_i,
  input  logic [31:0] ex_csr_wdata_i,
  input  logic [31:0] csr_rdata_i,
  output logic [11:0] csr_raddr_o,
  output logic        csr_re_o,
  output logic [11:0] csr_waddr_o,
  output logic        csr_we_o,
  output logic [31:0] csr_wdata_o,
  output logic        hold_o,
  output logic        jump_o,
  output logic [31:0] jump_addr_o
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    T_MEPC    = 4'd1,
    T_MCAUSE  = 4'd2,
    T_MSTATUS = 4'd3,
    T_JUMP    = 4'd4,
    R_EPC     = 4'd5,
    R_RDST    = 4'd6,
    R_WRST    = 4'd7,
    R_JUMP    = 4'd8
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] mst_q, mst_d;
  logic [31:0] tvec_q, tvec_d;
  logic [31:0] epc_q, epc_d;
  logic        mie_sh_q, mie_sh_d;
  logic        meie_sh_q, meie_sh_d;
  logic        irq_take_s;

  // An interrupt colliding with an execute-stage CSR write waits one cycle so the write lands first.
  assign irq_take_s = irq_i & mie_sh_q & meie_sh_q & ~ex_csr_we_i;

  // Next-state, latch capture and all CSR-port / pipeline-control outputs.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cause_d     = cause_q;
    mst_d       = mst_q;
    tvec_d      = tvec_q;
    epc_d       = epc_q;
    csr_raddr_o = 12'h000;
    csr_re_o    = 1'b0;
    csr_waddr_o = 12'h000;
    csr_we_o    = 1'b0;
    csr_wdata_o = 32'h0000_0000;
    hold_o      = 1'b1;
    jump_o      = 1'b0;
    jump_addr_o = 32'h0000_0000;
    case (state_q)
      IDLE: begin
        csr_raddr_o = ex_csr_raddr_i;
        csr_re_o    = ex_csr_re_i;
        csr_waddr_o = ex_csr_waddr_i;
        csr_we_o    = ex_csr_we_i;
        csr_wdata_o = ex_csr_wdata_i;
        if (mret_i) begin
          state_d = R_EPC;
          pc_d    = inst_addr_i;
          hold_o  = 1'b1;
        end else if (ecall_i || ebreak_i || irq_take_s) begin
          state_d = T_MEPC;
          pc_d    = inst_addr_i;
          hold_o  = 1'b1;
          if (ecall_i) begin
            cause_d = ECALL_CAUSE;
          end else if (ebreak_i) begin
            cause_d = EBREAK_CAUSE;
          end else begin
            cause_d = IRQ_CAUSE;
          end
        end else begin
          hold_o = 1'b0;
        end
      end
      T_MEPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MEPC;
        csr_wdata_o = pc_q;
        csr_re_o    = 1'b1;
        csr_raddr_o = CSR_MSTATUS;
        mst_d       = csr_rdata_i;
        state_d     = T_MCAUSE;
      end
      T_MCAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MCAUSE;
        csr_wdata_o = cause_q;
        state_d     = T_MSTATUS;
      end
      T_MSTATUS: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = {mst_q[31:8], mst_q[3], mst_q[6:4], 1'b0, mst_q[2:0]};
        csr_re_o    = 1'b1;
        csr_raddr_o = CSR_MTVEC;
        tvec_d      = csr_rdata_i;
        state_d     = T_JUMP;
      end
      T_JUMP: begin
        jump_o      = 1'b1;
        jump_addr_o = {tvec_q[31:2], 2'b00};
        state_d     = IDLE;
      end
      R_EPC: begin
        csr_re_o    = 1'b1;
        csr_raddr_o = CSR_MEPC;
        epc_d       = csr_rdata_i;
        state_d     = R_RDST;
      end
      R_RDST: begin
        csr_re_o    = 1'b1;
        csr_raddr_o = CSR_MSTATUS;
        mst_d       = csr_rdata_i;
        state_d     = R_WRST;
      end
      R_WRST: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = {mst_q[31:8], 1'b1, mst_q[6:4], mst_q[7], mst_q[2:0]};
        state_d     = R_JUMP;
      end
      R_JUMP: begin
        jump_o      = 1'b1;
        jump_addr_o = epc_q;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Shadow enables track every write leaving this block, including the sequencer's own.
  always_comb begin
    mie_sh_d  = mie_sh_q;
    meie_sh_d = meie_sh_q;
    if (csr_we_o && (csr_waddr_o == CSR_MSTATUS)) begin
      mie_sh_d = csr_wdata_o[3];
    end else if (csr_we_o && (csr_waddr_o == CSR_MIE)) begin
      meie_sh_d = csr_wdata_o[11];
    end else begin
      mie_sh_d  = mie_sh_q;
      meie_sh_d = meie_sh_q;
    end
  end

  // State, latches and shadow enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= 32'h0000_0000;
      cause_q   <= 32'h0000_0000;
      mst_q     <= 32'h0000_0000;
      tvec_q    <= 32'h0000_0000;
      epc_q     <= 32'h0000_0000;
      mie_sh_q  <= 1'b0;
      meie_sh_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cause_q   <= cause_d;
      mst_q     <= mst_d;
      tvec_q    <= tvec_d;
      epc_q     <= epc_d;
      mie_sh_q  <= mie_sh_d;
      meie_sh_q <= meie_sh_d;
    end
  end

endmodule
